// File: rtl/rr_mux_select_if.sv
// -----------------------------------------------------------------------------
// rr_mux_select_if
// Bundle of the request/grant signals between the requesters and the
// round-robin select sequencer that drives the 4:1 mux select lines.
//   en    : arbitration enable (requester side -> sequencer)
//   req   : per-channel request, req[i] asks for mux input i
//   s1,s0 : registered mux select (sequencer -> mux)
//   gnt   : one-hot grant, zero when nothing is granted
//   busy  : sequencer is granting or in the inter-grant gap
// Modports:
//   master : requester / environment side
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface rr_mux_select_if;
  logic       en;
  logic [3:0] req;
  logic       s1;
  logic       s0;
  logic [3:0] gnt;
  logic       busy;

  modport master (
    output en,
    output req,
    input  s1,
    input  s0,
    input  gnt,
    input  busy
  );

  modport slave (
    input  en,
    input  req,
    output s1,
    output s0,
    output gnt,
    output busy
  );
endinterface

// File: rtl/rr_mux_select.sv
// -----------------------------------------------------------------------------
// rr_mux_select
// Round-robin select sequencer sitting in front of a 4:1 mux. Grants one of
// four requesters at a time, holds the grant for at most MAX_HOLD cycles,
// and always inserts one idle (GAP) cycle between grants so the consumer
// sees a clean channel boundary. Every output is registered.
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles per channel (1..255)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rr_mux_select_if.slave (en, req in; s1, s0, gnt, busy out)
// -----------------------------------------------------------------------------
module rr_mux_select #(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_select_if.slave  bus
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] idx_reg, idx_next;
  logic [1:0] sel_reg, sel_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] gnt_reg, gnt_next;
  logic       busy_reg, busy_next;

  logic [3:0] req_rot;
  logic [1:0] pick_off;
  logic [1:0] pick;
  logic       start_grant;
  logic       release_grant;

  // Rotate the request vector so that bit 0 is the channel at ptr; a fixed
  // priority search over the rotated vector then gives the round-robin pick.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = bus.req[ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    pick_off = 2'd3;
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
  end

  assign pick          = ptr_reg + pick_off;
  assign start_grant   = bus.en && (|bus.req);
  // Any of the three conditions ends the grant; coincident conditions still
  // produce a single release and a single pointer advance.
  assign release_grant = !bus.req[idx_reg] || (cnt_reg == HOLD_LIMIT) || !bus.en;

  // State register (and the registered datapath that follows it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      idx_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      cnt_reg   <= 8'd0;
      gnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_grant) state_next = GRANT;
      GRANT:   if (release_grant) state_next = GAP;
      GAP:     state_next = start_grant ? GRANT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ptr_next = ptr_reg;
    idx_next = idx_reg;
    sel_next = sel_reg;
    cnt_next = cnt_reg;
    gnt_next = gnt_reg;
    unique case (state_reg)
      IDLE, GAP: begin
        gnt_next = 4'd0;
        if (start_grant) begin
          idx_next = pick;
          sel_next = pick;
          cnt_next = 8'd1;
          gnt_next = 4'b0001 << pick;
        end
      end
      GRANT: begin
        if (release_grant) begin
          gnt_next = 4'd0;
          ptr_next = idx_reg + 2'd1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: gnt_next = 4'd0;
    endcase
    // busy is registered alongside state so it equals (state != IDLE)
    busy_next = (state_next != IDLE);
  end

  assign bus.s1   = sel_reg[1];
  assign bus.s0   = sel_reg[0];
  assign bus.gnt  = gnt_reg;
  assign bus.busy = busy_reg;

endmodule

// File: tb/tb_rr_mux_select.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_select
// Three sequencers (MAX_HOLD = 3, 2, 1) share the same en/req/rst_n stimulus.
// A behavioural model (current holder, cycles held, round-robin start point)
// tracks each instance. Directed scenarios check literal expected patterns;
// a randomized run compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_rr_mux_select;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] req   = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_select_if if_h3 ();
  rr_mux_select_if if_h2 ();
  rr_mux_select_if if_h1 ();

  assign if_h3.en = en;  assign if_h3.req = req;
  assign if_h2.en = en;  assign if_h2.req = req;
  assign if_h1.en = en;  assign if_h1.req = req;

  rr_mux_select #(.MAX_HOLD(3)) dut_h3 (.clk(clk), .rst_n(rst_n), .bus(if_h3));
  rr_mux_select #(.MAX_HOLD(2)) dut_h2 (.clk(clk), .rst_n(rst_n), .bus(if_h2));
  rr_mux_select #(.MAX_HOLD(1)) dut_h1 (.clk(clk), .rst_n(rst_n), .bus(if_h1));

  logic [3:0] gnt_o  [3];
  logic [1:0] sel_o  [3];
  logic       busy_o [3];

  assign gnt_o[0] = if_h3.gnt;  assign sel_o[0] = {if_h3.s1, if_h3.s0};  assign busy_o[0] = if_h3.busy;
  assign gnt_o[1] = if_h2.gnt;  assign sel_o[1] = {if_h2.s1, if_h2.s0};  assign busy_o[1] = if_h2.busy;
  assign gnt_o[2] = if_h1.gnt;  assign sel_o[2] = {if_h1.s1, if_h1.s0};  assign busy_o[2] = if_h1.busy;

  // ---------------- behavioural reference model ----------------
  int hold_tab [3] = '{3, 2, 1};
  int m_cur    [3];   // channel currently holding the mux, -1 if none
  int m_held   [3];   // cycles the current holder has had the grant
  int m_start  [3];   // where the next round-robin search begins
  int m_sel    [3];   // last channel placed on the select lines
  bit m_gap    [3];   // in the mandatory one-cycle gap after a grant

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cur[k] = -1; m_held[k] = 0; m_start[k] = 0; m_sel[k] = 0; m_gap[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (m_cur[k] >= 0) begin
        if (!req[m_cur[k]] || m_held[k] == hold_tab[k] || !en) begin
          m_start[k] = (m_cur[k] + 1) % 4;
          m_cur[k]   = -1;
          m_gap[k]   = 1'b1;
        end else begin
          m_held[k]++;
        end
      end else begin
        m_gap[k] = 1'b0;
        if (en && req != 4'd0) begin
          for (int j = 3; j >= 0; j--)
            if (req[(m_start[k] + j) % 4]) m_cur[k] = (m_start[k] + j) % 4;
          m_held[k] = 1;
          m_sel[k]  = m_cur[k];
        end
      end
    end
  endtask

  function automatic logic [3:0] m_gnt(int k);
    return (m_cur[k] >= 0) ? 4'(1 << m_cur[k]) : 4'd0;
  endfunction

  function automatic logic m_busy(int k);
    return (m_cur[k] >= 0) || m_gap[k];
  endfunction

  // One clock: the edge samples the inputs set before it; outputs are then
  // observed at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'd0;
    en    = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    en = 1'b1; req = 4'd0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gnt_o[k] !== 4'd0 || sel_o[k] !== 2'd0 || busy_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d gnt=%b s=%b busy=%b want 0000/00/0", k, gnt_o[k], sel_o[k], busy_o[k]);
      end
    end
    rst_n = 1'b1;
    cycle();
    req = 4'b0100;
    cycle();
    checks++;
    if (gnt_o[0] !== 4'b0100 || sel_o[0] !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant gnt=%b s=%b want 0100/10", gnt_o[0], sel_o[0]);
    end
    cycle();
    // asynchronous reset in the middle of the grant, between edges
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gnt_o[k] !== 4'd0 || sel_o[k] !== 2'd0 || busy_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_grant dut%0d gnt=%b s=%b busy=%b want 0000/00/0", k, gnt_o[k], sel_o[k], busy_o[k]);
      end
    end
    req = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (gnt_o[0] !== 4'd0 || busy_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stays_idle cyc%0d gnt=%b busy=%b want 0000/0", c, gnt_o[0], busy_o[0]);
      end
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_load();
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      cycle();
      exp_sel = 2'((i % 16) / 4);
      exp_gnt = ((i % 4) < 3) ? (4'b0001 << exp_sel) : 4'd0;
      checks++;
      if (gnt_o[0] !== exp_gnt || sel_o[0] !== exp_sel || busy_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL full_load cyc%0d gnt=%b s=%b busy=%b want %b/%b/1", i, gnt_o[0], sel_o[0], busy_o[0], exp_gnt, exp_sel);
      end
    end
    $display("test_full_load done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_early_release();
    logic [3:0] exp_gnt [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic       exp_busy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 1) req = 4'b0000;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (gnt_o[k] !== exp_gnt[i] || sel_o[k] !== 2'b10 || busy_o[k] !== exp_busy[i]) begin
          errors++;
          $display("FAIL early_release dut%0d cyc%0d gnt=%b s=%b busy=%b want %b/10/%b",
                   k, i, gnt_o[k], sel_o[k], busy_o[k], exp_gnt[i], exp_busy[i]);
        end
      end
    end
    $display("test_early_release done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_wrap_around();
    logic [3:0] seen [$];
    do_reset();
    req = 4'b0100;  cycle();          // channel 2 granted
    req = 4'b1000;  cycle();          // 2 released, gap
    cycle();                          // channel 3 granted out of the gap
    checks++;
    if (gnt_o[0] !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_ch3_grant gnt=%b want 1000", gnt_o[0]);
    end
    req = 4'b0000;  cycle();          // channel 3 released, start wraps to 0
    req = 4'b1001;
    for (int i = 0; i < 16 && seen.size() < 2; i++) begin
      cycle();
      if (gnt_o[0] !== 4'd0 && (seen.size() == 0 || seen[$] !== gnt_o[0])) seen.push_back(gnt_o[0]);
    end
    checks++;
    if (seen.size() < 2 || seen[0] !== 4'b0001 || seen[1] !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_order got %0d grants first=%b second=%b want 0001 then 1000",
               seen.size(), (seen.size() > 0) ? seen[0] : 4'bxxxx, (seen.size() > 1) ? seen[1] : 4'bxxxx);
    end
    $display("test_wrap_around done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_requester();
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        exp_gnt = ((i % (hold_tab[k] + 1)) < hold_tab[k]) ? 4'b0010 : 4'b0000;
        checks++;
        if (gnt_o[k] !== exp_gnt || sel_o[k] !== 2'b01 || busy_o[k] !== 1'b1) begin
          errors++;
          $display("FAIL single_req hold%0d cyc%0d gnt=%b s=%b busy=%b want %b/01/1",
                   hold_tab[k], i, gnt_o[k], sel_o[k], busy_o[k], exp_gnt);
        end
      end
    end
    $display("test_single_requester done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_enable_gating();
    do_reset();
    req = 4'b1111;
    cycle(); cycle();
    checks++;
    if (gnt_o[0] !== 4'b0001) begin
      errors++;
      $display("FAIL enable_pre_grant gnt=%b want 0001", gnt_o[0]);
    end
    en = 1'b0;
    cycle();
    checks++;
    if (gnt_o[0] !== 4'd0 || busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_drop_gap gnt=%b busy=%b want 0000/1", gnt_o[0], busy_o[0]);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (gnt_o[0] !== 4'd0 || busy_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL enable_low_idle cyc%0d gnt=%b busy=%b want 0000/0", i, gnt_o[0], busy_o[0]);
      end
    end
    en = 1'b1;
    cycle();
    checks++;
    if (gnt_o[0] !== 4'b0010 || sel_o[0] !== 2'b01) begin
      errors++;
      $display("FAIL enable_resume gnt=%b s=%b want 0010/01", gnt_o[0], sel_o[0]);
    end
    $display("test_enable_gating done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (gnt_o[k] !== 4'd0 || sel_o[k] !== 2'd0 || busy_o[k] !== 1'b0) begin
            errors++;
            $display("FAIL random_reset dut%0d gnt=%b s=%b busy=%b want 0000/00/0", k, gnt_o[k], sel_o[k], busy_o[k]);
          end
        end
        #1 rst_n = 1'b1;
      end
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gnt_o[k] !== m_gnt(k) || sel_o[k] !== 2'(m_sel[k]) || busy_o[k] !== m_busy(k)) begin
          errors++;
          $display("FAIL random_model hold%0d cyc%0d gnt=%b s=%b busy=%b want %b/%b/%b",
                   hold_tab[k], i, gnt_o[k], sel_o[k], busy_o[k], m_gnt(k), 2'(m_sel[k]), m_busy(k));
        end
        checks++;
        if ($countones(gnt_o[k]) > 1 || (gnt_o[k] !== 4'd0 && gnt_o[k] !== (4'b0001 << sel_o[k]))) begin
          errors++;
          $display("FAIL random_invariant hold%0d cyc%0d gnt=%b s=%b want onehot matching s", hold_tab[k], i, gnt_o[k], sel_o[k]);
        end
      end
    end
    $display("test_random done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_load();
    test_early_release();
    test_wrap_around();
    test_single_requester();
    test_enable_gating();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
